// File: rtl/field_compositor.sv
// field_compositor: builds the per-frame display field for the tetris renderer.
// Snapshots the locked playfield, overlays the active piece one cell per cycle,
// applies line-clear flash blanking, then swaps the image into `display`.
// Optional feature macro: COMPOSE_STATS_EN (adds dropped_frames / max_busy_ok).
module field_compositor #(
  parameter int         FLASH_FRAMES     = 8,
  parameter int         FLASH_TOGGLES    = 6,
  parameter int         FIELD_VERTICAL   = 22,
  parameter int         FIELD_HORIZONTAL = 10,
  parameter logic [2:0] TETROMINO_EMPTY  = 3'd0
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                frame_start,
  input  logic [FIELD_VERTICAL-1:0][FIELD_HORIZONTAL-1:0][2:0] field_in,
  input  logic                                                piece_valid,
  input  logic [15:0]                                         piece_mask,
  input  logic [2:0]                                          piece_idx,
  input  logic signed [5:0]                                   piece_row,
  input  logic signed [5:0]                                   piece_col,
  input  logic                                                flash_start,
  input  logic [FIELD_VERTICAL-1:0]                           flash_rows,
  output logic [FIELD_VERTICAL-1:0][FIELD_HORIZONTAL-1:0][2:0] display,
  output logic                                                busy,
  output logic                                                frame_done,
  output logic                                                flash_active,
  output logic                                                overrun
`ifdef COMPOSE_STATS_EN
  ,
  output logic [15:0]                                         dropped_frames,
  output logic                                                max_busy_ok
`endif
);

  localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int TC_W = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;
  localparam int RW   = $clog2(FIELD_VERTICAL);
  localparam int CW   = $clog2(FIELD_HORIZONTAL);
  localparam logic signed [7:0] FV_S    = 8'(FIELD_VERTICAL);
  localparam logic signed [7:0] FH_S    = 8'(FIELD_HORIZONTAL);
  localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FLASH_FRAMES - 1);
  localparam logic [TC_W-1:0]   TC_LAST = TC_W'(FLASH_TOGGLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COPY    = 2'd1,
    ST_OVERLAY = 2'd2,
    ST_SWAP    = 2'd3
  } state_t;

  state_t state_r;
  logic [FIELD_VERTICAL-1:0][FIELD_HORIZONTAL-1:0][2:0] shadow_r;
  logic [3:0]                k_r;
  logic                      cap_valid_r;
  logic [15:0]               cap_mask_r;
  logic [2:0]                cap_idx_r;
  logic signed [5:0]         cap_row_r;
  logic signed [5:0]         cap_col_r;
  logic                      blank_r;
  logic [FIELD_VERTICAL-1:0] blank_rows_r;
  logic [FIELD_VERTICAL-1:0] flash_rows_r;
  logic                      phase_r;   // 0 = OFF (rows blanked), 1 = ON
  logic [FC_W-1:0]           frame_cnt_r;
  logic [TC_W-1:0]           toggle_cnt_r;

  logic                      accept_s;
  logic                      drop_s;
  logic signed [7:0]         tgt_row_s;
  logic signed [7:0]         tgt_col_s;
  logic                      hit_s;

  // Frame acceptance, drop detection and overlay target / in-bounds test.
  always_comb begin
    accept_s  = (state_r == ST_IDLE) && frame_start;
    drop_s    = (state_r != ST_IDLE) && frame_start;
    tgt_row_s = {{2{cap_row_r[5]}}, cap_row_r} + {6'd0, k_r[3:2]};
    tgt_col_s = {{2{cap_col_r[5]}}, cap_col_r} + {6'd0, k_r[1:0]};
    hit_s     = cap_valid_r && cap_mask_r[k_r] &&
                !tgt_row_s[7] && (tgt_row_s < FV_S) &&
                !tgt_col_s[7] && (tgt_col_s < FH_S);
  end

  // Compose FSM: capture, copy with flash blanking, per-cell overlay, swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      shadow_r     <= {(FIELD_VERTICAL*FIELD_HORIZONTAL){TETROMINO_EMPTY}};
      display      <= {(FIELD_VERTICAL*FIELD_HORIZONTAL){TETROMINO_EMPTY}};
      k_r          <= 4'd0;
      cap_valid_r  <= 1'b0;
      cap_mask_r   <= 16'd0;
      cap_idx_r    <= 3'd0;
      cap_row_r    <= 6'sd0;
      cap_col_r    <= 6'sd0;
      blank_r      <= 1'b0;
      blank_rows_r <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= drop_s;
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            cap_valid_r <= piece_valid;
            cap_mask_r  <= piece_mask;
            cap_idx_r   <= piece_idx;
            cap_row_r   <= piece_row;
            cap_col_r   <= piece_col;
            // A coincident flash_start composes this frame in the OFF phase.
            blank_r      <= flash_start | (flash_active & ~phase_r);
            blank_rows_r <= flash_start ? flash_rows : flash_rows_r;
            busy         <= 1'b1;
            state_r      <= ST_COPY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_COPY: begin
          for (int r = 0; r < FIELD_VERTICAL; r++) begin
            shadow_r[r] <= (blank_r && blank_rows_r[r]) ?
                           {FIELD_HORIZONTAL{TETROMINO_EMPTY}} : field_in[r];
          end
          k_r     <= 4'd0;
          state_r <= ST_OVERLAY;
        end
        ST_OVERLAY: begin
          if (hit_s) begin
            shadow_r[tgt_row_s[RW-1:0]][tgt_col_s[CW-1:0]] <= cap_idx_r;
          end
          if (k_r == 4'd15) begin
            state_r <= ST_SWAP;
          end else begin
            k_r <= k_r + 4'd1;
          end
        end
        ST_SWAP: begin
          display    <= shadow_r;
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Flash engine: phase toggles every FLASH_FRAMES accepted frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_active <= 1'b0;
      flash_rows_r <= '0;
      phase_r      <= 1'b0;
      frame_cnt_r  <= '0;
      toggle_cnt_r <= '0;
    end else if (flash_start) begin
      flash_active <= 1'b1;
      flash_rows_r <= flash_rows;
      phase_r      <= 1'b0;
      frame_cnt_r  <= '0;
      toggle_cnt_r <= '0;
    end else if (accept_s && flash_active) begin
      if (frame_cnt_r == FC_LAST) begin
        frame_cnt_r <= '0;
        phase_r     <= ~phase_r;
        if (toggle_cnt_r == TC_LAST) begin
          toggle_cnt_r <= '0;
          flash_active <= 1'b0;
        end else begin
          toggle_cnt_r <= toggle_cnt_r + TC_W'(1);
        end
      end else begin
        frame_cnt_r <= frame_cnt_r + FC_W'(1);
      end
    end else begin
      flash_active <= flash_active;
    end
  end

`ifdef COMPOSE_STATS_EN
  // Overrun statistics: saturating drop counter and sticky health flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_frames <= 16'd0;
      max_busy_ok    <= 1'b1;
    end else if (drop_s) begin
      max_busy_ok <= 1'b0;
      if (dropped_frames != 16'hFFFF) begin
        dropped_frames <= dropped_frames + 16'd1;
      end else begin
        dropped_frames <= dropped_frames;
      end
    end else begin
      max_busy_ok <= max_busy_ok;
    end
  end
`endif

endmodule
